// File: rtl/uart_frame_parser.sv
// uart_frame_parser: finds SYNC_BYTE-led frames in a UART byte stream, buffers
// the payload, verifies the XOR checksum and releases only good frames on a
// valid/ready stream. Rejected frames and dropped bytes raise frame_err.
module uart_frame_parser #(
  parameter int unsigned           DATA_BITS = 8,
  parameter int unsigned           MAX_LEN   = 16,
  parameter logic [DATA_BITS-1:0]  SYNC_BYTE = DATA_BITS'(8'hA5),
  parameter int unsigned           TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] byte_in,
  input  logic                 byte_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;

  state_t               state, state_d;
  logic [DATA_BITS-1:0] len_q, len_d;
  logic [DATA_BITS-1:0] csum_q, csum_d;
  logic [IW-1:0]        wr_idx, wr_d;
  logic [IW-1:0]        rd_idx, rd_d;
  logic [TW-1:0]        tmr, tmr_d;
  logic                 ok_d, err_d;
  logic [1:0]           code_d;
  logic                 buf_we;
  logic                 wr_last, rd_last;
  logic [DATA_BITS-1:0] frame_buf [MAX_LEN];

  assign wr_last = (DATA_BITS'(wr_idx) == len_q - DATA_BITS'(1));
  assign rd_last = (DATA_BITS'(rd_idx) == len_q - DATA_BITS'(1));

  // Drain-side view: driven from state and read index only
  assign out_data = frame_buf[rd_idx];
  assign out_last = (state == DRAIN) && rd_last;

  // Next-state, datapath updates and error/ok strobes
  always_comb begin
    state_d = state;
    len_d   = len_q;
    csum_d  = csum_q;
    wr_d    = wr_idx;
    rd_d    = rd_idx;
    tmr_d   = '0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_TIMEOUT;
    buf_we  = 1'b0;

    case (state)
      HUNT: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) state_d = LEN;
      end
      LEN: begin
        if (byte_valid) begin
          if ((byte_in == '0) || (byte_in > DATA_BITS'(MAX_LEN))) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = HUNT;
          end else begin
            len_d   = byte_in;
            csum_d  = byte_in;
            wr_d    = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_valid) begin
          buf_we = 1'b1;
          csum_d = csum_q ^ byte_in;
          if (wr_last) state_d = CHECK;
          else         wr_d    = wr_idx + IW'(1);
        end
      end
      CHECK: begin
        if (byte_valid) begin
          if (byte_in == csum_q) begin
            ok_d    = 1'b1;
            rd_d    = '0;
            state_d = DRAIN;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = HUNT;
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          if (rd_last) state_d = HUNT;
          else         rd_d    = rd_idx + IW'(1);
        end
        // Only one frame is held; anything arriving now is lost
        if (byte_valid) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
      end
      default: state_d = HUNT;
    endcase

    // Inter-byte watchdog inside a frame; an arriving byte always wins
    if (((state == LEN) || (state == PAYLOAD) || (state == CHECK)) && !byte_valid) begin
      if (tmr == TW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = HUNT;
      end else begin
        tmr_d = tmr + TW'(1);
      end
    end
  end

  // State, control registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      len_q     <= '0;
      csum_q    <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      tmr       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      wr_idx    <= wr_d;
      rd_idx    <= rd_d;
      tmr       <= tmr_d;
      out_valid <= (state_d == DRAIN);
      busy      <= (state_d != HUNT);
      frame_ok  <= ok_d;
      frame_err <= err_d;
      err_code  <= code_d;
    end
  end

  // Payload buffer, deliberately not reset
  always_ff @(posedge clk) begin
    if (buf_we) frame_buf[wr_idx] <= byte_in;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: byte-level reference model with per-cycle
// output comparison, directed frames with literal expectations, then random frames.
module tb_uart_frame_parser;

  localparam int unsigned ML = 16;
  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_last, frame_ok, frame_err, busy;
  logic [1:0] err_code;

  uart_frame_parser #(.DATA_BITS(8), .MAX_LEN(ML), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rdy_mode = 0;

  // Reference model: phase 0 idle, 1 expecting length, 2 collecting payload,
  // 3 expecting checksum, 4 handing bytes out
  int         ph = 0;
  int         flen = 0;
  int         idle = 0;
  logic [7:0] x = 8'h00;
  logic [7:0] pl[$];
  logic [7:0] dq[$];
  bit         e_ok, e_err;
  int         e_code;

  // Observations for the directed checks
  int         n_ok = 0, n_err = 0, last_code = -1, last_err_cyc = 0;
  logic [7:0] got[$];
  bit         got_last[$];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; flen = 0; idle = 0; x = 8'h00;
    pl.delete(); dq.delete();
    e_ok = 0; e_err = 0; e_code = 0;
  endtask

  task automatic model_step(input bit bv, input logic [7:0] b, input bit rdy);
    e_ok = 0; e_err = 0; e_code = 0;
    if (ph == 4) begin
      if (rdy) begin
        void'(dq.pop_front());
        if (dq.size() == 0) ph = 0;
      end
      if (bv) begin e_err = 1; e_code = 3; end
    end else if (ph == 0) begin
      if (bv && b == 8'hA5) begin ph = 1; idle = 0; end
    end else if (bv) begin
      idle = 0;
      if (ph == 1) begin
        if (b == 0 || int'(b) > ML) begin e_err = 1; e_code = 1; ph = 0; end
        else begin flen = int'(b); x = b; pl.delete(); ph = 2; end
      end else if (ph == 2) begin
        pl.push_back(b);
        x = x ^ b;
        if (pl.size() == flen) ph = 3;
      end else begin
        if (b == x) begin e_ok = 1; dq = pl; ph = 4; end
        else begin e_err = 1; e_code = 2; ph = 0; end
      end
    end else begin
      idle++;
      if (idle == TO) begin e_err = 1; e_code = 0; ph = 0; end
    end
  endtask

  // Step the model on each edge and compare the DUT just after it
  always @(posedge clk) begin
    bit         bv, rdy;
    logic [7:0] b;
    bv = byte_valid; b = byte_in; rdy = out_ready;
    if (!reset && out_valid && out_ready) begin
      got.push_back(out_data);
      got_last.push_back(out_last);
    end
    cyc++;
    if (reset) model_reset();
    else       model_step(bv, b, rdy);
    #1;
    chk("out_valid", int'(out_valid), int'(ph == 4));
    chk("busy", int'(busy), int'(ph != 0));
    chk("frame_ok", int'(frame_ok), int'(e_ok));
    chk("frame_err", int'(frame_err), int'(e_err));
    if (e_err || reset) chk("err_code", int'(err_code), e_code);
    if (ph == 4) begin
      chk("out_data", int'(out_data), int'(dq[0]));
      chk("out_last", int'(out_last), int'(dq.size() == 1));
    end
    if (frame_ok) n_ok++;
    if (frame_err) begin n_err++; last_code = int'(err_code); last_err_cyc = cyc; end
  end

  // Downstream ready pattern
  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    chk("wait_idle", int'(busy), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         g0, e0, o0, t0, len, kind;
    logic [7:0] cs, v;

    wait_n(3);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    wait_n(2);

    // Good 3-byte frame
    o0 = n_ok; g0 = got.size();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    wait_n(6);
    chk("f1_ok_count", n_ok - o0, 1);
    chk("f1_count", got.size() - g0, 3);
    if (got.size() - g0 == 3) begin
      chk("f1_b0", int'(got[g0]), 8'h11);
      chk("f1_b1", int'(got[g0+1]), 8'h22);
      chk("f1_b2", int'(got[g0+2]), 8'h33);
      chk("f1_last", int'({got_last[g0], got_last[g0+1], got_last[g0+2]}), 3'b001);
    end
    chk("f1_busy_after", int'(busy), 0);

    // Garbage ahead of a one-byte frame whose payload is the sync value
    g0 = got.size(); e0 = n_err;
    send(8'h00); send(8'hFF); send(8'h5A);
    send(8'hA5); send(8'h01); send(8'hA5); send(8'hA4);
    wait_n(4);
    chk("f2_count", got.size() - g0, 1);
    if (got.size() - g0 == 1) begin
      chk("f2_data", int'(got[g0]), 8'hA5);
      chk("f2_last", int'(got_last[g0]), 1);
    end
    chk("f2_no_err", n_err - e0, 0);

    // Bad checksum, zero length, oversize length
    g0 = got.size(); e0 = n_err;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    wait_n(3);
    chk("csum_err", n_err - e0, 1);
    chk("csum_code", last_code, 2);
    chk("csum_no_out", got.size() - g0, 0);
    e0 = n_err;
    send(8'hA5); send(8'h00); wait_n(3);
    chk("len0_err", n_err - e0, 1);
    chk("len0_code", last_code, 1);
    e0 = n_err;
    send(8'hA5); send(8'h11); wait_n(3);
    chk("len17_err", n_err - e0, 1);
    chk("len17_code", last_code, 1);

    // Backpressure with an overrun byte injected mid-drain
    rdy_mode = 1; g0 = got.size(); e0 = n_err;
    send(8'hA5); send(8'h03); send(8'h44); send(8'h55); send(8'h66); send(8'h74);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    send(8'h77);
    wait_n(10);
    rdy_mode = 0;
    chk("ovr_err", n_err - e0, 1);
    chk("ovr_code", last_code, 3);
    chk("ovr_count", got.size() - g0, 3);
    if (got.size() - g0 == 3) begin
      chk("ovr_b0", int'(got[g0]), 8'h44);
      chk("ovr_b1", int'(got[g0+1]), 8'h55);
      chk("ovr_b2", int'(got[g0+2]), 8'h66);
    end

    // Timeout after the last payload byte seen
    e0 = n_err;
    send(8'hA5); send(8'h02); send(8'h11);
    t0 = cyc;
    wait_n(110);
    chk("to_err", n_err - e0, 1);
    chk("to_code", last_code, 0);
    chk("to_delay", last_err_cyc - t0, 100);
    g0 = got.size();
    send(8'hA5); send(8'h01); send(8'h42); send(8'h43);
    wait_n(4);
    chk("to_next_count", got.size() - g0, 1);
    if (got.size() - g0 == 1) chk("to_next_data", int'(got[g0]), 8'h42);

    // Byte landing on the terminal count keeps the frame alive
    e0 = n_err; g0 = got.size();
    send(8'hA5); send(8'h02); send(8'h11);
    wait_n(99);
    send(8'h22); send(8'h31);
    wait_n(5);
    chk("to_edge_no_err", n_err - e0, 0);
    chk("to_edge_count", got.size() - g0, 2);

    // Asynchronous reset in the middle of a payload
    send(8'hA5); send(8'h04); send(8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_err", int'(frame_err), 0);
    chk("arst_ok", int'(frame_ok), 0);
    chk("arst_code", int'(err_code), 0);
    e0 = n_err;
    wait_n(2);
    reset = 1'b0;
    wait_n(3);
    chk("arst_no_err", n_err - e0, 0);
    g0 = got.size();
    send(8'hA5); send(8'h01); send(8'h09); send(8'h08);
    wait_n(4);
    chk("arst_next_count", got.size() - g0, 1);
    if (got.size() - g0 == 1) chk("arst_next_data", int'(got[g0]), 8'h09);

    // Random frames, random gaps and random ready
    rdy_mode = 2;
    for (int f = 0; f < 200; f++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 8) begin
        for (int i = 0; i < int'($urandom_range(1, 5)); i++) send(8'($urandom));
      end else if (kind == 7) begin
        send(8'hA5);
        send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(ML + 1, 255)));
      end else begin
        len = int'($urandom_range(1, ML));
        cs  = 8'(len);
        send(8'hA5); wait_n(int'($urandom_range(0, 2)));
        send(8'(len));
        for (int i = 0; i < len; i++) begin
          wait_n(int'($urandom_range(0, 2)));
          v = 8'($urandom);
          cs = cs ^ v;
          send(v);
        end
        wait_n(int'($urandom_range(0, 2)));
        if (kind == 6) send(cs ^ 8'($urandom_range(1, 255)));
        else           send(cs);
        if (kind == 9) begin
          for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
          send(8'($urandom));
        end
      end
      wait_idle();
      wait_n(int'($urandom_range(0, 3)));
    end

    rdy_mode = 0;
    wait_n(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Downstream consumer of the UART receiver's byte stream. It hunts for a sync byte, reads a length byte, stores the payload speculatively in an internal buffer, and checks an XOR checksum. Only frames that pass the check are released on a valid/ready output stream. Failed frames are discarded and reported with an error pulse and an error code.

## Interface
- DATA_BITS, 8, width of received bytes.
- MAX_LEN, 16, maximum payload length in bytes. Range 1..255.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 65535, maximum number of clk cycles allowed between bytes inside a frame.

- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- byte_in  in  DATA_BITS  received byte; sampled only when byte_valid=1.
- byte_valid  in  1  single-cycle strobe from the UART receiver (its data-ready pulse).
- out_data  out  DATA_BITS  payload byte; don't-care while out_valid=0.
- out_valid  out  1  a payload byte is available.
- out_ready  in  1  downstream accepts the byte.
- out_last  out  1  qualifies the final payload byte of a frame.
- frame_ok  out  1  one-cycle pulse when a frame's checksum matches.
- frame_err  out  1  one-cycle pulse when a frame is rejected or a byte is dropped.
- err_code  out  2  reason for the error; valid only while frame_err=1. 0 = timeout, 1 = bad length, 2 = checksum mismatch, 3 = overrun.
- busy  out  1  high in every state except HUNT.

## Operation
- States: HUNT, LEN, PAYLOAD, CHECK, DRAIN.
- Reset behaviour:
  - State goes to HUNT.
  - out_valid, out_last, frame_ok, frame_err, busy and err_code all go to 0.
  - Read index, write index, length and checksum registers clear to 0.
  - Buffer contents are left unchanged; they are not reset.
- HUNT:
  - byte_valid with byte_in==SYNC_BYTE moves to LEN.
  - Every other byte is ignored silently. No error is raised.
- LEN:
  - A byte equal to 0 or greater than MAX_LEN pulses frame_err with err_code=1 and returns to HUNT.
  - Otherwise: len = byte, csum = byte, wr_idx = 0, move to PAYLOAD.
- PAYLOAD:
  - Each byte is written to buf[wr_idx], then csum ^= byte and wr_idx++.
  - The byte written at wr_idx == len-1 moves the FSM to CHECK.
  - SYNC_BYTE values inside the payload are treated as ordinary data.
- CHECK:
  - The next byte is compared against csum.
  - Equal: pulse frame_ok, set rd_idx = 0, move to DRAIN.
  - Not equal: pulse frame_err with err_code=2, return to HUNT. The buffer is abandoned and nothing is output.
- DRAIN:
  - out_valid = 1 and out_data = buf[rd_idx].
  - out_last = (rd_idx == len-1).
  - Each cycle with out_valid && out_ready advances rd_idx.
  - Acceptance of the out_last byte returns the FSM to HUNT, with out_valid low on the next cycle.
  - A byte_valid arriving during DRAIN is dropped and pulses frame_err with err_code=3. The drain continues unaffected.
- Timeout (LEN, PAYLOAD and CHECK only):
  - A counter clears on every byte_valid and increments every other cycle.
  - When it reaches TIMEOUT: pulse frame_err with err_code=0 and return to HUNT.
  - If byte_valid coincides with the terminal count, the byte wins and the counter clears.
  - The counter holds at 0 in HUNT and DRAIN.
- Checksum width is DATA_BITS. It is the XOR of the length byte and all payload bytes.
- Index registers are clog2(MAX_LEN) bits wide (minimum 1). No index wraps past len-1.
- Only one frame is buffered. No new frame is accepted until the drain completes.

## Timing
- All outputs are registered except out_data and out_last. Those two are combinational from the buffer and rd_idx, and depend only on state (not on inputs).
- frame_ok, frame_err and err_code assert in the cycle after the clock edge that samples the triggering byte or timeout, and last exactly one cycle.
- out_valid rises in the same cycle as frame_ok, one cycle after the checksum byte is sampled.
- With out_ready held high, a frame of len N drains in N consecutive cycles.
- out_valid, once asserted, stays high and out_data stays stable until the handshake completes.
- Asynchronous reset at any point aborts the frame immediately. No frame_err pulse is emitted.

## Test plan
- Valid frame: send A5 03 11 22 33 03 with out_ready=1.
  - Expect frame_ok once.
  - Expect out_data 11, 22, 33 on consecutive cycles, with out_last only on 33.
  - Expect busy low afterwards.
- Garbage then a frame: send 00 FF 5A, then A5 01 A5 A4.
  - The leading bytes are ignored.
  - Expect a single output byte A5 with out_last=1.
- Bad frames:
  - A5 03 11 22 33 00 gives frame_err with err_code=2 and no out_valid.
  - A5 00 gives err_code=1.
  - A5 11 (17 > MAX_LEN) gives err_code=1.
- Backpressure and overrun: after a valid 3-byte frame, toggle out_ready on alternate cycles and inject byte 77 during DRAIN.
  - Expect frame_err with err_code=3.
  - Expect all three bytes still delivered in order, with out_data held while out_ready=0.
- Timeout: set TIMEOUT=100, send A5 02 11, then idle.
  - Expect frame_err with err_code=0 exactly 100 cycles after the 11 strobe.
  - Then send A5 01 42 43 and expect 42 to be delivered.
  - Separately, a byte arriving at cycle 100 exactly must prevent the timeout.
- Reset mid-PAYLOAD: assert reset after A5 04 01.
  - All outputs go to 0 and no error pulse is emitted.
  - A following A5 01 09 08 is delivered correctly.
